// File: rtl/conv_mac_seq_controller.sv
// KxK x CH convolution-window MAC sequencer: issues image/weight BRAM reads and accumulates signed products.
// Optional build macro CONV_MAC_RELU_EN clamps negative results to zero when the result is registered.
module conv_mac_seq_controller #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int K      = 3,
    parameter int CH     = 1,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int IMG_AW = 10,
    parameter int W_AW   = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [IMG_AW-1:0]        s_img_addr,
    input  logic [W_AW-1:0]          s_w_addr,
    input  logic signed [DATA_W-1:0] img_data,
    input  logic signed [DATA_W-1:0] w_data,
    output logic [IMG_AW-1:0]        img_addr,
    output logic [W_AW-1:0]          w_addr,
    output logic                     d_ena,
    output logic signed [ACC_W-1:0]  calc_data,
    output logic                     done,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam logic [2:0] K_LAST = 3'(K - 1);
    localparam logic [3:0] C_LAST = 4'(CH - 1);
    localparam logic [1:0] D_LAST = 2'(RD_LAT - 1);

    state_t                   r_state, w_state_n;
    logic [3:0]               r_c, w_c_n;
    logic [2:0]               r_ky, r_kx, w_ky_n, w_kx_n;
    logic [1:0]               r_drain;
    logic [IMG_AW-1:0]        r_img_base, r_img_addr;
    logic [W_AW-1:0]          r_w_base, r_w_addr;
    logic                     r_d_ena, r_done, r_busy;
    logic [RD_LAT-1:0]        r_vld_p;
    logic signed [ACC_W-1:0]  r_acc, r_calc;
    logic                     w_last_tap, w_drain_end, w_accept;

    function automatic logic [IMG_AW-1:0] img_tap(input logic [IMG_AW-1:0] base, input logic [3:0] c,
                                                  input logic [2:0] ky, input logic [2:0] kx);
        logic [31:0] sum;
        sum = 32'(base) + 32'(c) * 32'(IMG_W * IMG_H) + 32'(ky) * 32'(IMG_W) + 32'(kx);
        return sum[IMG_AW-1:0];
    endfunction

    function automatic logic [W_AW-1:0] w_tap(input logic [W_AW-1:0] base, input logic [3:0] c,
                                              input logic [2:0] ky, input logic [2:0] kx);
        logic [31:0] sum;
        sum = 32'(base) + 32'(c) * 32'(K * K) + 32'(ky) * 32'(K) + 32'(kx);
        return sum[W_AW-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [DATA_W-1:0] a,
                                                          input logic signed [DATA_W-1:0] b);
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        return ACC_W'(p);
    endfunction

    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] a);
`ifdef CONV_MAC_RELU_EN
        return a[ACC_W-1] ? '0 : a;
`else
        return a;
`endif
    endfunction

    always_comb begin
        w_accept    = (r_state == IDLE) && start;
        w_last_tap  = (r_c == C_LAST) && (r_ky == K_LAST) && (r_kx == K_LAST);
        w_drain_end = (r_drain == D_LAST);
        w_kx_n = r_kx + 3'd1;
        w_ky_n = r_ky;
        w_c_n  = r_c;
        if (r_kx == K_LAST) begin
            w_kx_n = 3'd0;
            w_ky_n = r_ky + 3'd1;
            if (r_ky == K_LAST) begin
                w_ky_n = 3'd0;
                w_c_n  = r_c + 4'd1;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (start)       w_state_n = ISSUE;
            ISSUE:   if (w_last_tap)  w_state_n = DRAIN;
            DRAIN:   if (w_drain_end) w_state_n = FINISH;
            FINISH:                   w_state_n = IDLE;
            default:                  w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_n;
    end

    // Stage p0: tap sequencing and registered BRAM address/enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= '0; r_ky <= '0; r_kx <= '0; r_drain <= '0;
            r_img_base <= '0; r_w_base <= '0; r_img_addr <= '0; r_w_addr <= '0;
            r_d_ena <= 1'b0; r_done <= 1'b0; r_busy <= 1'b0; r_calc <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_img_base <= s_img_addr;
                    r_w_base   <= s_w_addr;
                    r_img_addr <= s_img_addr;
                    r_w_addr   <= s_w_addr;
                    r_c <= '0; r_ky <= '0; r_kx <= '0;
                    r_d_ena <= 1'b1;
                    r_busy  <= 1'b1;
                end
                ISSUE: if (w_last_tap) begin
                    r_d_ena <= 1'b0;
                    r_drain <= '0;
                end else begin
                    r_c <= w_c_n; r_ky <= w_ky_n; r_kx <= w_kx_n;
                    r_img_addr <= img_tap(r_img_base, w_c_n, w_ky_n, w_kx_n);
                    r_w_addr   <= w_tap(r_w_base, w_c_n, w_ky_n, w_kx_n);
                end
                DRAIN: r_drain <= r_drain + 2'd1;
                FINISH: begin
                    r_calc <= relu(r_acc);
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Stage p1..pRD_LAT: valid follows the BRAM read pipeline into the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p <= '0;
            r_acc   <= '0;
        end else begin
            r_vld_p[0] <= r_d_ena;
            for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
            if (w_accept)                 r_acc <= '0;
            else if (r_vld_p[RD_LAT-1])   r_acc <= r_acc + sext_prod(img_data, w_data);
        end
    end

    assign img_addr  = r_img_addr;
    assign w_addr    = r_w_addr;
    assign d_ena     = r_d_ena;
    assign calc_data = r_calc;
    assign done      = r_done;
    assign busy      = r_busy;

endmodule

// File: tb/tb_conv_mac_seq_controller.sv
// Scoreboard bench: instance A (K=3, CH=1, RD_LAT=1) and instance B (K=3, CH=2, RD_LAT=3, 11-bit image address).
module tb_conv_mac_seq_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    logic signed [7:0] img_mem [0:2047];
    logic signed [7:0] w_mem   [0:255];

    // Instance A
    logic              a_start = 1'b0;
    logic [9:0]        a_s_img = '0;
    logic [7:0]        a_s_w   = '0;
    logic signed [7:0] a_img_q, a_w_q;
    logic [9:0]        a_img_addr;
    logic [7:0]        a_w_addr;
    logic              a_d_ena, a_done, a_busy;
    logic [23:0]       a_calc;

    conv_mac_seq_controller dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .s_img_addr(a_s_img), .s_w_addr(a_s_w),
        .img_data(a_img_q), .w_data(a_w_q), .img_addr(a_img_addr), .w_addr(a_w_addr),
        .d_ena(a_d_ena), .calc_data(a_calc), .done(a_done), .busy(a_busy)
    );

    always @(posedge clk) if (a_d_ena) begin
        a_img_q <= img_mem[{1'b0, a_img_addr}];
        a_w_q   <= w_mem[a_w_addr];
    end

    // Instance B
    logic              b_start = 1'b0;
    logic [10:0]       b_s_img = '0;
    logic [7:0]        b_s_w   = '0;
    logic signed [7:0] b_i1, b_i2, b_i3, b_w1, b_w2, b_w3;
    logic [10:0]       b_img_addr;
    logic [7:0]        b_w_addr;
    logic              b_d_ena, b_done, b_busy;
    logic [23:0]       b_calc;

    conv_mac_seq_controller #(.CH(2), .RD_LAT(3), .IMG_AW(11)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .s_img_addr(b_s_img), .s_w_addr(b_s_w),
        .img_data(b_i3), .w_data(b_w3), .img_addr(b_img_addr), .w_addr(b_w_addr),
        .d_ena(b_d_ena), .calc_data(b_calc), .done(b_done), .busy(b_busy)
    );

    always @(posedge clk) begin
        if (b_d_ena) begin
            b_i1 <= img_mem[b_img_addr];
            b_w1 <= w_mem[b_w_addr];
        end
        b_i2 <= b_i1; b_w2 <= b_w1;
        b_i3 <= b_i2; b_w3 <= b_w2;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] model(input int s_img, input int s_w, input int ch, input int img_words);
        logic [23:0] acc;
        int ia, wa;
        acc = '0;
        for (int c = 0; c < ch; c++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++) begin
                    ia = (s_img + c * 1024 + ky * 32 + kx) % img_words;
                    wa = (s_w + c * 9 + ky * 3 + kx) % 256;
                    acc = acc + 24'(int'(img_mem[ia]) * int'(w_mem[wa]));
                end
`ifdef CONV_MAC_RELU_EN
        if (acc[23]) acc = '0;
`endif
        return acc;
    endfunction

    int a_res_q[$], a_done_q[$], a_ia_q[$], a_wa_q[$];
    int b_res_q[$], b_done_q[$];
    int b_base_i = 0, b_base_w = 0;

    task automatic a_expect(input int s_img, input int s_w, input int edge_no);
        a_res_q.push_back(int'(model(s_img, s_w, 1, 1024)));
        a_done_q.push_back(edge_no + 9 + 1 + 1);
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                a_ia_q.push_back((s_img + ky * 32 + kx) % 1024);
                a_wa_q.push_back((s_w + ky * 3 + kx) % 256);
            end
    endtask

    task automatic go_a(input int s_img, input int s_w, output int edge_no);
        @(negedge clk);
        a_s_img = 10'(s_img);
        a_s_w   = 8'(s_w);
        a_start = 1'b1;
        edge_no = cyc + 1;
        a_expect(s_img, s_w, edge_no);
        @(negedge clk);
        a_start = 1'b0;
        check("a_busy_set", 32'(a_busy), 32'd1);
    endtask

    task automatic go_b(input int s_img, input int s_w);
        @(negedge clk);
        b_s_img = 11'(s_img);
        b_s_w   = 8'(s_w);
        b_base_i = s_img;
        b_base_w = s_w;
        b_start = 1'b1;
        b_res_q.push_back(int'(model(s_img, s_w, 2, 2048)));
        b_done_q.push_back(cyc + 1 + 18 + 3 + 1);
        @(negedge clk);
        b_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((a_res_q.size() + b_res_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((a_res_q.size() + b_res_q.size()) != 0) begin
            check("timeout", 32'd0, 32'd1);
            a_res_q.delete(); a_done_q.delete(); a_ia_q.delete(); a_wa_q.delete();
            b_res_q.delete(); b_done_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic fill(input int iv, input int wv, input bit rnd);
        for (int i = 0; i < 2048; i++) img_mem[i] = rnd ? 8'($urandom) : 8'(iv);
        for (int i = 0; i < 256; i++)  w_mem[i]   = rnd ? 8'($urandom) : 8'(wv);
    endtask

    always @(negedge clk) begin
        if (a_d_ena) begin
            if (a_ia_q.size() == 0) check("a_extra_read", 32'd1, 32'd0);
            else begin
                check("a_img_addr", 32'(a_img_addr), 32'(a_ia_q.pop_front()));
                check("a_w_addr", 32'(a_w_addr), 32'(a_wa_q.pop_front()));
            end
        end
        if (a_done) begin
            if (a_res_q.size() == 0) check("a_spurious_done", 32'd1, 32'd0);
            else begin
                check("a_result", 32'(a_calc), 32'(a_res_q.pop_front()));
                check("a_latency", 32'(cyc), 32'(a_done_q.pop_front()));
                check("a_busy_clr", 32'(a_busy), 32'd0);
            end
        end
    end

    int b_tap = 0, b_run = 0;
    always @(negedge clk) begin
        if (b_d_ena) begin
            if (b_tap == 9) begin
                check("b_ch1_img", 32'(b_img_addr), 32'((b_base_i + 1024) % 2048));
                check("b_ch1_w", 32'(b_w_addr), 32'((b_base_w + 9) % 256));
            end
            if (b_tap == 17) begin
                check("b_last_img", 32'(b_img_addr), 32'((b_base_i + 1024 + 66) % 2048));
                check("b_last_w", 32'(b_w_addr), 32'((b_base_w + 17) % 256));
            end
            b_tap++;
            b_run++;
        end else if (b_run != 0) begin
            check("b_ena_run", 32'(b_run), 32'd18);
            b_run = 0;
            b_tap = 0;
        end
        if (b_done) begin
            if (b_res_q.size() == 0) check("b_spurious_done", 32'd1, 32'd0);
            else begin
                check("b_result", 32'(b_calc), 32'(b_res_q.pop_front()));
                check("b_latency", 32'(cyc), 32'(b_done_q.pop_front()));
            end
        end
    end

    initial begin
        int t, t2;
        fill(1, 1, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_img_addr", 32'(a_img_addr), 32'd0);
        check("rst_w_addr", 32'(a_w_addr), 32'd0);
        check("rst_d_ena", 32'(a_d_ena), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_calc", 32'(a_calc), 32'd0);
        rst_n = 1'b1;

        go_a(0, 0, t);
        wait_idle(100);
        check("a_ones", 32'(a_calc), 32'h000009);

        fill(-1, 2, 1'b0);
        go_a(0, 0, t);
        wait_idle(100);
`ifdef CONV_MAC_RELU_EN
        check("a_neg", 32'(a_calc), 32'h000000);
`else
        check("a_neg", 32'(a_calc), 32'hFFFFEE);
`endif

        fill(0, 0, 1'b1);
        go_a(1000, 250, t);
        wait_idle(100);

        // ignored start at t+4, start held across FINISH edge t+11, accepted at t+12
        go_a(7, 3, t);
        while (cyc < t + 3) @(negedge clk);
        a_start = 1'b1;
        a_s_img = 10'd100;
        @(negedge clk);
        a_start = 1'b0;
        while (cyc < t + 10) @(negedge clk);
        a_start = 1'b1;
        a_s_img = 10'd200;
        a_s_w   = 8'd40;
        a_expect(200, 40, t + 12);
        while (cyc < t + 12) @(negedge clk);
        a_start = 1'b0;
        check("a_busy_restart", 32'(a_busy), 32'd1);
        wait_idle(100);

        // reset mid-window aborts it; outputs clear at once
        fill(1, 1, 1'b0);
        go_a(0, 0, t);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_img_addr", 32'(a_img_addr), 32'd0);
        check("abort_w_addr", 32'(a_w_addr), 32'd0);
        check("abort_d_ena", 32'(a_d_ena), 32'd0);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_calc", 32'(a_calc), 32'd0);
        a_res_q.delete(); a_done_q.delete(); a_ia_q.delete(); a_wa_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        fill(0, 0, 1'b1);
        go_a(2, 5, t2);
        wait_idle(100);

        fill(3, -4, 1'b0);
        go_b(5, 10);
        wait_idle(100);
`ifdef CONV_MAC_RELU_EN
        check("b_const", 32'(b_calc), 32'h000000);
`else
        check("b_const", 32'(b_calc), 32'hFFFF28);
`endif
        fill(0, 0, 1'b1);
        go_b(2040, 250);
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_mac_seq_controller.md
Name: conv_mac_seq_controller

Overview:
- Parametrised successor to the single-window multi-MAC controller.
- Sequences reads of one KxK convolution window across CH input channels from an image BRAM and a weight BRAM, and multiply-accumulates signed samples into one result.
- Sits between the dual-port BRAM read ports (enable, address, registered dout) and the downstream result collector.
- Adds configurable kernel size, channel count, image row/plane stride, BRAM read latency and a busy indicator.

Parameters:
DATA_W, 8, sample width of img_data / w_data (signed two's complement)
ACC_W, 24, accumulator and calc_data width
K, 3, kernel side length (1..7)
CH, 1, input channels per window (1..16)
IMG_W, 32, image row stride in words
IMG_H, 32, image rows per channel plane
IMG_AW, 10, image address width
W_AW, 8, weight address width
RD_LAT, 1, BRAM read latency in cycles (1..3)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start request, sampled only in IDLE
s_img_addr  input  IMG_AW  window top-left address, channel 0
s_w_addr  input  W_AW  weight base address, channel 0
img_data  input  DATA_W  image BRAM dout
w_data  input  DATA_W  weight BRAM dout
img_addr  output  IMG_AW  image BRAM address
w_addr  output  W_AW  weight BRAM address
d_ena  output  1  BRAM read enable, shared by both memories
calc_data  output  ACC_W  accumulated result
done  output  1  one-cycle completion pulse
busy  output  1  high from start acceptance until done

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; img_addr, w_addr, calc_data, accumulator and counters cleared; d_ena, done and busy low. Reset mid-operation aborts the window with no done pulse.
- FSM states: IDLE -> ISSUE -> DRAIN -> FINISH -> IDLE.
- IDLE:
  - On start=1, latch s_img_addr and s_w_addr, clear the accumulator and tap counters (kx, ky, c), set busy=1, go to ISSUE.
  - start=0 keeps the FSM in IDLE.
- ISSUE:
  - Runs for N = CH*K*K cycles with d_ena=1.
  - Tap order: kx fastest, then ky, then c.
  - img_addr = s_img_addr + c*IMG_W*IMG_H + ky*IMG_W + kx.
  - w_addr = s_w_addr + c*K*K + ky*K + kx.
  - Addresses are registered outputs; each wraps modulo 2^IMG_AW or 2^W_AW with no error flag.
  - After the last tap, go to DRAIN.
- DRAIN:
  - d_ena=0 for RD_LAT cycles.
  - The addresses of the last tap are held.
- Accumulate path:
  - A valid-tracking shift register of depth RD_LAT follows d_ena.
  - When the delayed valid is 1, acc <= acc + sext(img_data*w_data), using a 2*DATA_W signed product sign-extended to ACC_W.
  - Overflow wraps modulo 2^ACC_W.
- FINISH (one cycle):
  - calc_data <= final accumulator, done=1, busy=0, then return to IDLE.
  - calc_data holds its value until the next FINISH.
- Latency: done is asserted exactly N+RD_LAT+1 cycles after the clock edge that sampled start. Example: K=3, CH=1, RD_LAT=1 gives 11 cycles.
- start=1 while busy=1 is ignored, with no queuing.
- start=1 held in the FINISH cycle is not accepted in that cycle. It is accepted on the next edge when the FSM is back in IDLE.
- Back-to-back windows therefore have N+RD_LAT+2 cycles between start edges.

Optional Feature:
- Macro CONV_MAC_RELU_EN.
- Defined: in FINISH, calc_data <= 0 if the accumulator is negative (MSB=1), otherwise the accumulator.
- Undefined: calc_data is the raw signed accumulator. No extra logic is generated.
- Timing is identical in both builds.

Test Plan:
- K=3, CH=1, RD_LAT=1, all img and weight words = 1, s_img_addr=0, s_w_addr=0, start pulse -> img_addr sequence 0,1,2,32,33,34,64,65,66; w_addr 0..8; done 11 cycles after start; calc_data=24'h000009.
- Same setup, img words = 8'hFF (-1), weights = 2 -> calc_data=24'hFFFFEE (-18). With CONV_MAC_RELU_EN defined -> calc_data=0.
- CH=2, K=3, s_img_addr=5, s_w_addr=10 -> second-channel taps begin at img_addr=1029 and w_addr=19; d_ena high for 18 consecutive cycles; done after 20 cycles.
- RD_LAT=3, img=3, w=-4, K=3, CH=1 -> done 13 cycles after start; calc_data=-108 (24'hFFFF94).
- start pulsed again at cycles 4 and the FINISH cycle of a running window -> no restart, single done, result unchanged; start held through FINISH is accepted on the following edge.
- rst_n driven low at cycle 5 of a window, then released and a new start issued -> outputs clear immediately, no done for the aborted window, new window result correct.
